eq_serial_ctrl_amisha: RTL and testbench

//  Sequencer that compares two WIDTH-bit words for equality through one shared 1-bit equality cell.

---
 rtl/eq_serial_ctrl_amisha_pkg.sv | 11 +
 rtl/eq_serial_ctrl_amisha_eq1.sv | 10 +
 rtl/eq_serial_ctrl_amisha.sv | 124 ++++++++++++
 tb/tb_eq_serial_ctrl_amisha.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_serial_ctrl_amisha_pkg.sv
// Shared definitions for the serial equality controller: FSM state encoding and width.
package eq_serial_ctrl_amisha_pkg;

  localparam int unsigned StateW = 1;

  typedef enum logic [StateW-1:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/eq_serial_ctrl_amisha_eq1.sv
// 1-bit equality cell (XNOR), used as the shared bit comparator by eq_serial_ctrl_amisha.
module eq1_implicit_amisha (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o
);

  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/eq_serial_ctrl_amisha.sv
// Bit-serial WIDTH-bit equality compare, LSB first, through one shared 1-bit cell.
// Optional macro EQ_SERIAL_EARLY_EXIT_EN ends the compare at the first mismatching bit.
module eq_serial_ctrl_amisha
  import eq_serial_ctrl_amisha_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             eq_amisha,
  output logic [CW-1:0]    mismatch_idx_amisha
);

  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             acc_eq_q, acc_eq_d;
  logic [CW-1:0]    mm_idx_q, mm_idx_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             cell_eq;
  logic             first_mm;

  eq1_implicit_amisha u_eq1 (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .eq_o (cell_eq)
  );

  // A mismatch only counts as "first" while the accumulator is still clean.
  assign first_mm = acc_eq_q & ~cell_eq;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_eq_d = acc_eq_q;
    mm_idx_d = mm_idx_q;
    eq_d     = eq_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_amisha) begin
          state_d  = StShift;
          a_sh_d   = a_amisha;
          b_sh_d   = b_amisha;
          cnt_d    = '0;
          acc_eq_d = 1'b1;
          mm_idx_d = '0;
        end
      end
      StShift: begin
        acc_eq_d = acc_eq_q & cell_eq;
        if (first_mm) begin
          mm_idx_d = cnt_q;
        end
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        if (first_mm) begin
          state_d = StIdle;
          done_d  = 1'b1;
          eq_d    = 1'b0;
          idx_d   = cnt_q;
          cnt_d   = '0;
        end else if (cnt_q == LastIdx) begin
`else
        if (cnt_q == LastIdx) begin
`endif
          state_d = StIdle;
          done_d  = 1'b1;
          eq_d    = acc_eq_d;
          idx_d   = acc_eq_d ? '0 : mm_idx_d;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_eq_q <= 1'b0;
      mm_idx_q <= '0;
      eq_q     <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_eq_q <= acc_eq_d;
      mm_idx_q <= mm_idx_d;
      eq_q     <= eq_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy_amisha         = (state_q == StShift);
  assign done_amisha         = done_q;
  assign eq_amisha           = eq_q;
  assign mismatch_idx_amisha = idx_q;

endmodule

// File: tb/tb_eq_serial_ctrl_amisha.sv
// Scoreboard bench for eq_serial_ctrl_amisha (WIDTH=8); honours EQ_SERIAL_EARLY_EXIT_EN.
module tb_eq_serial_ctrl_amisha;

  localparam int W = 8;

  typedef struct {
    logic       eq;
    logic [2:0] idx;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, eq;
  logic [2:0] idx;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic       last_eq = 1'b0;
  logic [2:0] last_idx = '0;

  always #5 clk = ~clk;

  eq_serial_ctrl_amisha #(.WIDTH(W)) dut (
    .clk_amisha          (clk),
    .reset_amisha        (reset),
    .start_amisha        (start),
    .a_amisha            (a),
    .b_amisha            (b),
    .busy_amisha         (busy),
    .done_amisha         (done),
    .eq_amisha           (eq),
    .mismatch_idx_amisha (idx)
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    bit   found = 0;
    e.eq  = 1'b1;
    e.idx = '0;
    e.lat = W;
    for (int i = 0; i < W; i++) begin
      if (!found && x[i] != y[i]) begin
        found = 1;
        e.eq  = 1'b0;
        e.idx = 3'(i);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        e.lat = i + 1;
`endif
      end
    end
    return e;
  endfunction

  // Drives start for exactly one edge (E0); operands are scrambled afterwards.
  task automatic start_cmp(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    sb.push_back(model(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Waits for done after E0; optionally pulses an ignored start at edge inj.
  task automatic wait_done(input string name, input int inj);
    exp_t e;
    bit   seen = 0;
    e = sb.pop_front();
    for (int n = 1; n <= W + 4 && !seen; n++) begin
      if (inj != 0 && n == inj) begin
        start = 1'b1; a = 8'h00; b = 8'hFF;
      end
      @(posedge clk); #1;
      if (inj != 0 && n == inj) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1;
        tests++;
        if (n !== e.lat) begin
          fails++; $display("FAIL %s latency: got %0d, want %0d", name, n, e.lat);
        end
        tests++;
        if (eq !== e.eq) begin
          fails++; $display("FAIL %s eq: got %b, want %b", name, eq, e.eq);
        end
        tests++;
        if (idx !== e.idx) begin
          fails++; $display("FAIL %s idx: got %0d, want %0d", name, idx, e.idx);
        end
        tests++;
        if (busy !== 1'b0) begin
          fails++; $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
        end
        last_eq  = e.eq;
        last_idx = e.idx;
      end else begin
        tests++;
        if (busy !== 1'b1 || eq !== last_eq || idx !== last_idx) begin
          fails++;
          $display("FAIL %s cycle %0d busy/eq/idx: got %b/%b/%0d, want 1/%b/%0d",
                   name, n, busy, eq, idx, last_eq, last_idx);
        end
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d cycles, want %0d", name, W + 4, e.lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if ({busy, done, eq, idx} !== 6'b0) begin
      fails++; $display("FAIL reset outputs: got %b, want 000000", {busy, done, eq, idx});
    end
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL reset_idle busy/done: got %b/%b, want 0/0", busy, done);
      end
    end
  endtask

  task automatic test_equal;
    start_cmp(8'hA5, 8'hA5);
    wait_done("equal", 0);
  endtask

  task automatic test_lsb_mismatch;
    start_cmp(8'hA5, 8'hA4);
    wait_done("lsb_mismatch", 0);
  endtask

  task automatic test_msb_mismatch;
    start_cmp(8'h80, 8'h00);
    wait_done("msb_mismatch", 0);
  endtask

  task automatic test_back_to_back;
    start_cmp(8'h3C, 8'h3C);
    wait_done("ignored_start", 3);
    start_cmp(8'hFF, 8'hFF);
    wait_done("back_to_back", 0);
  endtask

  task automatic test_reset_mid;
    bit spurious = 0;
    start_cmp(8'h12, 8'h34);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    tests++;
    if ({busy, done, eq, idx} !== 6'b0) begin
      fails++; $display("FAIL reset_mid outputs: got %b, want 000000", {busy, done, eq, idx});
    end
    last_eq  = 1'b0;
    last_idx = '0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done !== 1'b0) spurious = 1;
    end
    tests++;
    if (spurious) begin
      fails++; $display("FAIL reset_mid done: got pulse, want none");
    end
    start_cmp(8'h5A, 8'h1A);
    wait_done("after_reset", 0);
  endtask

  task automatic test_random;
    logic [7:0] x, y;
    for (int i = 0; i < 8; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 2) == 0) ? x : 8'($urandom);
      start_cmp(x, y);
      wait_done("random", 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset;
    test_equal;
    test_lsb_mismatch;
    test_msb_mismatch;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
